// File: rtl/glitch_filter_pkg.sv
// Shared types and default constants for the glitch filter.
package glitch_filter_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    QUALIFY = 1'b1
  } state_t;

  localparam int DEF_STABLE_CYCLES = 4;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int GLITCH_CNT_W      = 8;

endpackage

// File: rtl/glitch_filter_sync_chain.sv
// Multi-flop synchronizer bringing the asynchronous input into the clk domain.
module sync_chain #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  // NOTE: non-blocking, so each stage takes the previous stage's old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule

// File: rtl/glitch_filter.sv
// Debounces an asynchronous level: a change reaches dout only after it has held
// for STABLE_CYCLES synchronized cycles; shorter excursions are counted as glitches.
module glitch_filter
  import glitch_filter_pkg::*;
#(
  parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter logic RESET_VAL     = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    din,
  input  logic                    enable,
  output logic                    dout,
  output logic                    rise,
  output logic                    fall,
  output logic                    busy,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
);

  localparam int              CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic                    w_s;
  state_t                  r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
  logic                    r_dout, w_dout_nxt;
  logic                    r_rise, w_rise_nxt;
  logic                    r_fall, w_fall_nxt;
  logic [GLITCH_CNT_W-1:0] r_glitch_cnt, w_glitch_cnt_nxt;

  sync_chain #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(RESET_VAL)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (din),
    .q    (w_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= STABLE;
      r_cnt        <= '0;
      r_dout       <= RESET_VAL;
      r_rise       <= 1'b0;
      r_fall       <= 1'b0;
      r_glitch_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_dout       <= w_dout_nxt;
      r_rise       <= w_rise_nxt;
      r_fall       <= w_fall_nxt;
      r_glitch_cnt <= w_glitch_cnt_nxt;
    end
  end

  // NOTE: every output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_dout_nxt       = r_dout;
    w_rise_nxt       = 1'b0;
    w_fall_nxt       = 1'b0;
    w_glitch_cnt_nxt = r_glitch_cnt;

    if (!enable) begin
      // Abandoning a candidate because of enable is not a glitch.
      w_state_nxt = STABLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        STABLE: begin
          if (w_s != r_dout) begin
            w_state_nxt = QUALIFY;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
        QUALIFY: begin
          if (w_s == r_dout) begin
            w_state_nxt = STABLE;
            w_cnt_nxt   = '0;
            if (r_glitch_cnt != '1) begin
              w_glitch_cnt_nxt = r_glitch_cnt + GLITCH_CNT_W'(1);
            end
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = STABLE;
            w_cnt_nxt   = '0;
            w_dout_nxt  = w_s;
            w_rise_nxt  = w_s;
            w_fall_nxt  = ~w_s;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = STABLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign dout       = r_dout;
  assign rise       = r_rise;
  assign fall       = r_fall;
  assign busy       = (r_state == QUALIFY);
  assign glitch_cnt = r_glitch_cnt;

endmodule

// File: tb/tb_glitch_filter.sv
// Self-checking bench for glitch_filter: fixed vector table, corner sequences,
// and randomized stimulus against a run-length reference model.
module tb_glitch_filter;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;

  logic       clk;
  logic       rst_n;
  logic       din;
  logic       enable;
  logic       dout;
  logic       rise;
  logic       fall;
  logic       busy;
  logic [7:0] glitch_cnt;

  int n_checks = 0;
  int n_errors = 0;

  glitch_filter #(
    .STABLE_CYCLES(STABLE),
    .SYNC_STAGES  (SYNC),
    .RESET_VAL    (1'b0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .enable    (enable),
    .dout      (dout),
    .rise      (rise),
    .fall      (fall),
    .busy      (busy),
    .glitch_cnt(glitch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Reference model: the filter seen as "count consecutive enabled cycles on
  // which the synchronized input disagrees with the output".
  bit m_hist[$];
  int m_run;
  bit m_dout, m_rise, m_fall;
  int m_gc;

  function automatic void model_reset();
    m_hist = {};
    for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
    m_run  = 0;
    m_dout = 1'b0;
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_gc   = 0;
  endfunction

  function automatic void model_step(bit d, bit en);
    bit s;
    s      = m_hist[SYNC-1];
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (!en) begin
      m_run = 0;
    end else if (s != m_dout) begin
      m_run++;
      if (m_run == STABLE) begin
        m_dout = s;
        m_rise = s;
        m_fall = !s;
        m_run  = 0;
      end
    end else if (m_run > 0) begin
      m_run = 0;
      if (m_gc < 255) m_gc++;
    end
    void'(m_hist.pop_back());
    m_hist.push_front(d);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: model follows the edge, outputs are then sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(din, enable);
    @(negedge clk);
  endtask

  function automatic logic [11:0] outs();
    return {dout, rise, fall, busy, glitch_cnt};
  endfunction

  task automatic do_reset();
    rst_n  = 1'b0;
    din    = 1'b0;
    enable = 1'b1;
    model_reset();
    repeat (3) tick();
    check("reset_state", 32'(outs()), 32'h0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_after_reset", 32'(outs()), 32'h0);
  endtask

  typedef struct {
    logic       d;
    logic       e;
    logic       o;
    logic       r;
    logic       f;
    logic       b;
    logic [7:0] g;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic d, logic e, logic o, logic r, logic f, logic b, logic [7:0] g);
    vec_t v;
    v.d = d; v.e = e; v.o = o; v.r = r; v.f = f; v.b = b; v.g = g;
    vecs.push_back(v);
  endfunction

  initial begin
    logic rise_seen;
    logic [11:0] exp_o;

    // Long high then long low: rise on edge 6, busy 3 cycles, then fall.
    add(1,1,0,0,0,0,0); add(1,1,0,0,0,0,0); add(1,1,0,0,0,1,0); add(1,1,0,0,0,1,0);
    add(1,1,0,0,0,1,0); add(1,1,1,1,0,0,0); add(1,1,1,0,0,0,0); add(1,1,1,0,0,0,0);
    add(1,1,1,0,0,0,0); add(1,1,1,0,0,0,0);
    add(0,1,1,0,0,0,0); add(0,1,1,0,0,0,0); add(0,1,1,0,0,1,0); add(0,1,1,0,0,1,0);
    add(0,1,1,0,0,1,0); add(0,1,0,0,1,0,0); add(0,1,0,0,0,0,0); add(0,1,0,0,0,0,0);
    // Exactly STABLE_CYCLES high: passes, dout high for 4 cycles.
    add(1,1,0,0,0,0,0); add(1,1,0,0,0,0,0); add(1,1,0,0,0,1,0); add(1,1,0,0,0,1,0);
    add(0,1,0,0,0,1,0); add(0,1,1,1,0,0,0); add(0,1,1,0,0,1,0); add(0,1,1,0,0,1,0);
    add(0,1,1,0,0,1,0); add(0,1,0,0,1,0,0); add(0,1,0,0,0,0,0); add(0,1,0,0,0,0,0);
    // Three cycles high: rejected, one glitch counted.
    add(1,1,0,0,0,0,0); add(1,1,0,0,0,0,0); add(1,1,0,0,0,1,0); add(0,1,0,0,0,1,0);
    add(0,1,0,0,0,1,0); add(0,1,0,0,0,0,1); add(0,1,0,0,0,0,1); add(0,1,0,0,0,0,1);
    // Enable dropped mid-qualify: no glitch; dout follows 4 cycles after re-enable.
    add(1,1,0,0,0,0,1); add(1,1,0,0,0,0,1); add(1,1,0,0,0,1,1); add(1,1,0,0,0,1,1);
    add(1,0,0,0,0,0,1); add(1,0,0,0,0,0,1); add(1,1,0,0,0,1,1); add(1,1,0,0,0,1,1);
    add(1,1,0,0,0,1,1); add(1,1,1,1,0,0,1); add(1,1,1,0,0,0,1);

    do_reset();
    foreach (vecs[i]) begin
      din    = vecs[i].d;
      enable = vecs[i].e;
      tick();
      exp_o = {vecs[i].o, vecs[i].r, vecs[i].f, vecs[i].b, vecs[i].g};
      check($sformatf("vec%0d", i), 32'(outs()), 32'(exp_o));
    end

    // Repeated short pulses: glitch count saturates at 255, dout never moves.
    do_reset();
    rise_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      din = 1'b1;
      repeat (3) begin tick(); rise_seen |= rise | dout; end
      din = 1'b0;
      repeat (5) begin tick(); rise_seen |= rise | dout; end
      if (i == 0)   check("glitch_first", 32'(glitch_cnt), 32'd1);
      if (i == 253) check("glitch_254", 32'(glitch_cnt), 32'd254);
    end
    check("glitch_saturated", 32'(glitch_cnt), 32'd255);
    check("glitch_no_rise", 32'(rise_seen), 32'd0);

    // Reset asserted while qualifying: candidate dropped, then re-qualified.
    do_reset();
    din = 1'b1;
    repeat (4) tick();
    check("busy_before_rst", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_qualify", 32'(outs()), 32'h0);
    model_reset();
    repeat (2) tick();
    check("rst_held", 32'(outs()), 32'h0);
    rst_n = 1'b1;
    rise_seen = 1'b0;
    repeat (5) begin tick(); rise_seen |= rise | dout; end
    check("rst_release_5", 32'(rise_seen), 32'd0);
    tick();
    check("rst_release_6", 32'({dout, rise, glitch_cnt}), 32'({2'b11, 8'd0}));

    // Randomized runs against the model.
    do_reset();
    for (int r = 0; r < 300; r++) begin
      din = 1'($urandom_range(0, 1));
      for (int k = 0, len = $urandom_range(1, 8); k < len; k++) begin
        enable = ($urandom_range(0, 9) != 0);
        tick();
        check("rand", 32'(outs()),
              32'({m_dout, m_rise, m_fall, (m_run > 0), 8'(m_gc)}));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
